pipeline_stall_controller: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Merges single-cycle hazards
//  (load-use, JAL in ID, taken branch/JALR in EX) with multi-cycle waits (data-memory handshake,

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_stall_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding,
// the NOP instruction loaded by a flush, and a small state classification helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_e;

  // addi x0, x0, 0 -- what the datapath writes into a flushed pipeline register
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_MEM_WAIT) || (s == ST_MDU_WAIT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges single-cycle hazards with
// data-memory and MDU waits, drives stage enables/flushes, and keeps perf counters.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_i,
  input  logic             jal_redirect_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             mdu_start_i,
  input  logic             mdu_done_i,
  output logic             en_pc_o,
  output logic             en_ifid_o,
  output logic             en_idex_o,
  output logic             en_exmem_o,
  output logic             en_memwb_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             flush_exmem_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             timeout_o
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic              freeze;
  logic              mdu_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Which wait (if any) owns this cycle; the remaining hazard rows only apply otherwise.
  always_comb begin
    state_d  = ST_RUN;
    freeze   = 1'b0;
    mdu_hold = 1'b0;
    unique case (state_q)
      ST_MEM_WAIT: begin
        if (!dmem_ready_i) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (mdu_start_i && !mdu_done_i) begin
          mdu_hold = 1'b1;
          state_d  = ST_MDU_WAIT;
        end
      end
      ST_MDU_WAIT: begin
        // MEM carries a bubble while the MDU is busy, so dmem_req_i is irrelevant here
        if (!mdu_done_i) begin
          mdu_hold = 1'b1;
          state_d  = ST_MDU_WAIT;
        end
      end
      default: begin
        if (dmem_req_i && !dmem_ready_i) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (mdu_start_i && !mdu_done_i) begin
          mdu_hold = 1'b1;
          state_d  = ST_MDU_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    en_pc_o       = 1'b1;
    en_ifid_o     = 1'b1;
    en_idex_o     = 1'b1;
    en_exmem_o    = 1'b1;
    en_memwb_o    = 1'b1;
    flush_ifid_o  = 1'b0;
    flush_idex_o  = 1'b0;
    flush_exmem_o = 1'b0;
    if (freeze) begin
      en_pc_o    = 1'b0;
      en_ifid_o  = 1'b0;
      en_idex_o  = 1'b0;
      en_exmem_o = 1'b0;
      en_memwb_o = 1'b0;
    end else if (mdu_hold) begin
      en_pc_o       = 1'b0;
      en_ifid_o     = 1'b0;
      en_idex_o     = 1'b0;
      flush_exmem_o = 1'b1;
    end else if (ex_redirect_i) begin
      // the ID instruction is wrong-path, so any load-use stall on it is moot
      flush_ifid_o = 1'b1;
      flush_idex_o = 1'b1;
    end else if (load_use_i) begin
      en_pc_o      = 1'b0;
      en_ifid_o    = 1'b0;
      flush_idex_o = 1'b1;
    end else if (jal_redirect_i) begin
      flush_ifid_o = 1'b1;
    end
    if (!rst_n) begin
      en_pc_o       = 1'b0;
      en_ifid_o     = 1'b0;
      en_idex_o     = 1'b0;
      en_exmem_o    = 1'b0;
      en_memwb_o    = 1'b0;
      flush_ifid_o  = 1'b0;
      flush_idex_o  = 1'b0;
      flush_exmem_o = 1'b0;
    end
  end

  // Wait counter parks at TIMEOUT-1 so a very long wait cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (is_wait_state(state_q)) begin
      if (wait_cnt_q != WAIT_LAST) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end else begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!en_pc_o),
    .count (stall_cycles_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_ifid_o),
    .count (flush_count_o)
  );

  assign state_o   = state_q;
  assign timeout_o = timeout_q;

endmodule
